// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg: shared types and default widths for the voice allocator.
//   state_t     - allocator FSM state encoding
//   NOTE_W_DEF  - default note number width
//   AGE_W_DEF   - default per-voice age counter width
package voice_alloc_pkg;

    localparam int NOTE_W_DEF = 7;
    localparam int AGE_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        ISSUE,
        HOLD
    } state_t;

endpackage

// File: rtl/voice_alloc_if.sv
// voice_alloc_if: note event handshake between a note source and the allocator.
//   note_valid - event offered by the source
//   note_ready - allocator can take the event this cycle
//   note_on    - 1 = note-on, 0 = note-off
//   note_num   - note number of the event
// master = note source, slave = allocator.
interface voice_alloc_if #(
    parameter int NOTE_W = voice_alloc_pkg::NOTE_W_DEF
) ();

    logic              note_valid;
    logic              note_ready;
    logic              note_on;
    logic [NOTE_W-1:0] note_num;

    modport master (output note_valid, output note_on, output note_num, input  note_ready);
    modport slave  (input  note_valid, input  note_on, input  note_num, output note_ready);

endinterface

// File: rtl/voice_select.sv
// voice_select: combinational voice choice for the allocator.
//   i_owned/i_released/i_active/i_age/i_note - registered per-voice state
//   i_num        - note number being looked up
//   o_match      - some owned voice already holds i_num
//   o_match_idx  - lowest-index such voice
//   o_valid      - a voice is available for a note-on
//   o_sel        - chosen voice for a note-on
// Priority: retrigger, free voice, oldest released voice, oldest voice.
// The last step exists only when VOICE_STEAL_EN is defined.
module voice_select #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int AGE_W      = 8,
    parameter int SEL_W      = 2
) (
    input  logic [NUM_VOICES-1:0]             i_owned,
    input  logic [NUM_VOICES-1:0]             i_released,
    input  logic [NUM_VOICES-1:0]             i_active,
    input  logic [NUM_VOICES-1:0][AGE_W-1:0]  i_age,
    input  logic [NUM_VOICES-1:0][NOTE_W-1:0] i_note,
    input  logic [NOTE_W-1:0]                 i_num,
    output logic                              o_match,
    output logic [SEL_W-1:0]                  o_match_idx,
    output logic                              o_valid,
    output logic [SEL_W-1:0]                  o_sel
);

    logic             w_free;
    logic [SEL_W-1:0] w_free_idx;
    logic             w_rel;
    logic [SEL_W-1:0] w_rel_idx;
    logic [AGE_W-1:0] w_rel_age;
`ifdef VOICE_STEAL_EN
    logic [SEL_W-1:0] w_any_idx;
    logic [AGE_W-1:0] w_any_age;
`endif

    always_comb begin
        o_match     = 1'b0;
        o_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        w_rel       = 1'b0;
        w_rel_idx   = '0;
        w_rel_age   = '0;
`ifdef VOICE_STEAL_EN
        w_any_idx   = '0;
        w_any_age   = i_age[0];
`endif
        // Ascending scan: first hit wins, strict '>' keeps the lowest index on age ties.
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!o_match && i_owned[i] && (i_note[i] == i_num)) begin
                o_match     = 1'b1;
                o_match_idx = SEL_W'(i);
            end
            if (!w_free && !i_owned[i] && !i_active[i]) begin
                w_free     = 1'b1;
                w_free_idx = SEL_W'(i);
            end
            if (i_owned[i] && i_released[i] && (!w_rel || (i_age[i] > w_rel_age))) begin
                w_rel     = 1'b1;
                w_rel_idx = SEL_W'(i);
                w_rel_age = i_age[i];
            end
`ifdef VOICE_STEAL_EN
            if (i_age[i] > w_any_age) begin
                w_any_idx = SEL_W'(i);
                w_any_age = i_age[i];
            end
`endif
        end

        o_valid = 1'b1;
        if (o_match)     o_sel = o_match_idx;
        else if (w_free) o_sel = w_free_idx;
        else if (w_rel)  o_sel = w_rel_idx;
        else begin
`ifdef VOICE_STEAL_EN
            o_sel   = w_any_idx;
`else
            o_sel   = '0;
            o_valid = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: assigns note events to a pool of ADSR voices.
//   clk, reset_n     - clock, asynchronous active-low reset
//   note_bus         - note event handshake (slave side)
//   i_voice_active   - per-voice ADSR busy
//   o_voice_start    - one-cycle start pulse per voice
//   o_voice_note     - note owned by each voice, voice i at [i*NOTE_W +: NOTE_W]
//   o_evt_steal      - pulse when a busy voice is taken over
//   o_evt_drop       - pulse when a note-on finds no voice
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice instead of dropping).
// A note-on takes IDLE->LOOKUP->ISSUE->HOLD; HOLD gives the ADSR one cycle to raise
// voice_active before the next lookup can see the voice.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = NOTE_W_DEF,
    parameter int AGE_W      = AGE_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    voice_alloc_if.slave                   note_bus,
    input  logic [NUM_VOICES-1:0]          i_voice_active,
    output logic [NUM_VOICES-1:0]          o_voice_start,
    output logic [NUM_VOICES*NOTE_W-1:0]   o_voice_note,
    output logic                           o_evt_steal,
    output logic                           o_evt_drop
);

    localparam int SEL_W = $clog2(NUM_VOICES);

    state_t                           r_state, w_next;
    logic                             r_on;
    logic [NOTE_W-1:0]                r_num;
    logic [SEL_W-1:0]                 r_sel;
    logic                             r_iss;
    logic [NUM_VOICES-1:0]            r_owned, r_rel;
    logic [NUM_VOICES-1:0][AGE_W-1:0] r_age;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] r_note;
`ifdef VOICE_STEAL_EN
    logic                             r_steal;
`endif

    logic             w_match, w_valid;
    logic [SEL_W-1:0] w_match_idx, w_sel;

    voice_select #(
        .NUM_VOICES(NUM_VOICES), .NOTE_W(NOTE_W), .AGE_W(AGE_W), .SEL_W(SEL_W)
    ) u_select (
        .i_owned(r_owned), .i_released(r_rel), .i_active(i_voice_active),
        .i_age(r_age), .i_note(r_note), .i_num(r_num),
        .o_match(w_match), .o_match_idx(w_match_idx),
        .o_valid(w_valid), .o_sel(w_sel)
    );

    assign o_voice_note = r_note;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next              = r_state;
        note_bus.note_ready = 1'b0;
        o_voice_start       = '0;
        o_evt_steal         = 1'b0;
        o_evt_drop          = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by reset_n so ready stays low while reset is held.
                note_bus.note_ready = reset_n;
                if (note_bus.note_valid) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (!r_on)        w_next = IDLE;
                else if (w_valid) w_next = ISSUE;
                else              w_next = HOLD;
`ifndef VOICE_STEAL_EN
                o_evt_drop = r_on && !w_valid;
`endif
            end
            ISSUE: begin
                w_next               = HOLD;
                o_voice_start[r_sel] = 1'b1;
`ifdef VOICE_STEAL_EN
                o_evt_steal          = r_steal;
`endif
            end
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_on    <= 1'b0;
            r_num   <= '0;
            r_sel   <= '0;
            r_iss   <= 1'b0;
            r_owned <= '0;
            r_rel   <= '0;
            r_age   <= '0;
            r_note  <= '0;
`ifdef VOICE_STEAL_EN
            r_steal <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && note_bus.note_valid) begin
                r_on  <= note_bus.note_on;
                r_num <= note_bus.note_num;
            end
            if (r_state == LOOKUP) begin
                r_sel <= w_sel;
                r_iss <= r_on && w_valid;
`ifdef VOICE_STEAL_EN
                r_steal <= i_voice_active[w_sel] && !w_match;
`endif
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (r_state == ISSUE && r_sel == SEL_W'(i)) begin
                    r_age[i]   <= '0;
                    r_owned[i] <= 1'b1;
                    r_rel[i]   <= 1'b0;
                    r_note[i]  <= r_num;
                end else begin
                    if (i_voice_active[i] && (r_age[i] != {AGE_W{1'b1}}))
                        r_age[i] <= r_age[i] + 1'b1;
                    // A just-issued voice is shielded through HOLD while its ADSR launches.
                    if (r_owned[i] && !i_voice_active[i] &&
                        !(r_state == HOLD && r_iss && r_sel == SEL_W'(i))) begin
                        r_owned[i] <= 1'b0;
                        r_rel[i]   <= 1'b0;
                    end else if (r_state == LOOKUP && !r_on && w_match &&
                                 w_match_idx == SEL_W'(i)) begin
                        r_rel[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of adsr voices scheduled (2..16).
REQ-002 SHALL have parameter NOTE_W, default 7, note number width.
REQ-003 SHALL have parameter AGE_W, default 8, per-voice saturating age counter width.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 note_valid  input  1  note event offered.
REQ-007 note_ready  output  1  event accepted when note_valid && note_ready.
REQ-008 note_on  input  1  1 = note-on, 0 = note-off.
REQ-009 note_num  input  NOTE_W  note number of event.
REQ-010 voice_active  input  NUM_VOICES  per-voice adsr busy (adsr not idle).
REQ-011 voice_start  output  NUM_VOICES  one-cycle start pulse per voice.
REQ-012 voice_note  output  NUM_VOICES*NOTE_W  registered note owned by each voice.
REQ-013 evt_steal  output  1  one-cycle pulse when a busy voice is stolen.
REQ-014 evt_drop  output  1  one-cycle pulse when a note-on is discarded.

Function
REQ-015 FSM states: IDLE, LOOKUP, ISSUE, HOLD; note_ready SHALL be 1 only in IDLE.
REQ-016 Accept in IDLE latches note_on/note_num; next state LOOKUP.
REQ-017 LOOKUP (note-on) SHALL register selected voice by priority: owned voice with same note (retrigger); else lowest-index voice with owned=0 and voice_active=0; else lowest-index released voice with max age; else lowest-index voice with max age (steal); next ISSUE.
REQ-018 ISSUE SHALL pulse voice_start[sel] for exactly one cycle, write voice_note[sel], set owned[sel]=1, released[sel]=0, age[sel]=0; next HOLD.
REQ-019 Stealing a voice with voice_active=1 and owner note different SHALL pulse evt_steal in the ISSUE cycle.
REQ-020 HOLD SHALL last one cycle (covers adsr idle->launch->attack so voice_active rises before next LOOKUP); next IDLE.
REQ-021 Note-on latency: accept at cycle T, voice_start at T+2, note_ready high again at T+4.
REQ-022 LOOKUP (note-off) SHALL set released=1 on the owned voice matching note_num (lowest index if several); no match is ignored; next IDLE, no voice_start.
REQ-023 Every cycle, each voice with voice_active=1 SHALL increment age, saturating at 2**AGE_W-1.
REQ-024 A voice with owned=1, voice_active=0, not in ISSUE/HOLD for that voice, SHALL clear owned and released; voice_note retains last value.
REQ-025 Age ties SHALL resolve to lowest index; selection SHALL use only registered state sampled in LOOKUP.
REQ-026 A note-off arriving while the same note is retriggered is processed strictly in acceptance order.

Reset
REQ-027 reset_n low SHALL force state IDLE, note_ready=0 during reset then 1, voice_start=0, evt_steal=0, evt_drop=0, voice_note=0, owned=0, released=0, age=0.
REQ-028 Reset mid-ISSUE SHALL suppress any partial voice_start pulse; the in-flight event is lost.

Configuration
REQ-029 Macro VOICE_STEAL_EN defined: steal step of REQ-017 active, evt_drop held 0.
REQ-030 VOICE_STEAL_EN undefined: when no retrigger/free/released voice exists, LOOKUP SHALL pulse evt_drop, skip ISSUE, go to HOLD; evt_steal held 0.

Structure
REQ-031 Package voice_alloc_pkg SHALL hold the state enum typedef and default constants NOTE_W_DEF, AGE_W_DEF.
REQ-032 Sub-module voice_select SHALL implement the combinational priority/max-age selection of REQ-017 and REQ-025.

Verification
REQ-033 Reset, note-on 60 -> voice_start=0001 at T+2, voice_note[0]=60, note_ready high at T+4.
REQ-034 Four note-ons 60,62,64,65 with all voices held active -> starts on voices 0,1,2,3 in order.
REQ-035 Voice 2 owns 64, note-on 64 again -> voice_start=0100, no evt_steal.
REQ-036 All busy, note-off 62 then note-on 67 -> voice 1 restarted, voice_note[1]=67, evt_steal=1.
REQ-037 All busy, none released, ages 10,40,40,5, note-on 70 -> voice 1 selected (with VOICE_STEAL_EN); without macro -> evt_drop=1, no voice_start.
REQ-038 reset_n pulsed low during ISSUE -> no voice_start pulse, all outputs at reset values.
